id_ex_pipe_reg: RTL
===================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the five-stage CPU core. It sits between the decode stage and the execute stage and carries the WB/MEM/EX control groups and the operand, immediate, PC and register-address fields. Unlike a plain latch, it tracks a per-entry valid bit, holds its contents on a global stall, inserts bubbles on branch flush, detects load-use hazards against its own entry, and counts the bubbles it inserts.

## Interface
Parameters:
- DATA_W, 32, width of pc, rsdata, rtdata, imm fields
- REG_AW, 5, register-address width
- WB_W, 2, WB control group width
- MEM_W, 3, MEM control group width
- EX_W, 4, EX control group width
- MEM_RD_BIT, 0, index within the MEM group that is MemRead (load)
- CNT_W, 16, bubble-counter width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  the decode stage presents a real instruction
- wb_i / mem_i / ex_i  in  WB_W / MEM_W / EX_W  control groups from decode
- pc_i, rsdata_i, rtdata_i, imm_i  in  DATA_W  data fields
- rsaddr_i, rtaddr_i, rdaddr_i  in  REG_AW  register addresses
- uses_rt_i  in  1  the decoded instruction reads rt as a source
- flush_i  in  1  squash the incoming instruction (branch taken)
- stall_i  in  1  global downstream stall; freeze this register
- valid_o  out  1  EX-stage entry is a real instruction
- wb_o / mem_o / ex_o  out  WB_W / MEM_W / EX_W  registered control groups
- pc_o, rsdata_o, rtdata_o, imm_o  out  DATA_W  registered data fields
- rsaddr_o, rtaddr_o, rdaddr_o  out  REG_AW  registered addresses
- hazard_o  out  1  load-use stall request to PC and IF/ID (combinational)
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

## Operation
- Load-use detect (combinational): raw_hz = valid_o & mem_o[MEM_RD_BIT] & (rtaddr_o != 0) & valid_i & ((rsaddr_i == rtaddr_o) | (uses_rt_i & (rtaddr_i == rtaddr_o))).
- hazard_o = raw_hz & ~flush_i. A squashed instruction never waits.
- Update priority per edge: rst_i, then stall_i, then flush_i, then hazard_o, then normal load.
  - stall_i=1: every output register and the counter hold their values, including valid_o.
  - Bubble (flush_i=1, or hazard_o=1): valid_o←0; wb_o, mem_o and ex_o←0. Data and address fields hold their previous values. bubble_cnt_o increments.
  - Load: valid_o←valid_i. Every field←its input. Control groups are loaded as zero when valid_i=0. The control outputs are therefore all-zero whenever valid_o=0.
- bubble_cnt_o saturates at 2^CNT_W−1 and never wraps. It has no clear other than reset.
- A load-use hazard self-clears. The bubble makes valid_o=0 on the next cycle, so raw_hz drops and the held decode instruction loads one cycle later. The stall lasts exactly one cycle.
- Register 0 never produces a hazard.

## Timing
- Reset (asynchronous, takes effect immediately): valid_o=0. All control, data and address outputs are 0. bubble_cnt_o=0. hazard_o is therefore 0.
- Decode-to-EX latency is 1 cycle. All outputs are registered except hazard_o, which is valid in the same cycle as its inputs.
- Deasserting rst_i mid-operation: the first edge after deassertion behaves as a normal edge. Nothing survives reset.
- stall_i together with flush_i: stall wins and nothing changes. The upstream stage must hold flush_i until the stall releases.
- flush_i together with raw_hz: one bubble is inserted, the counter increments by 1, and hazard_o=0.
- valid_i=0 with no flush or hazard: this is a load of an invalid entry. It is not a bubble and the counter does not change.

## Test plan
- Reset: assert rst_i between edges → all outputs 0 immediately; after release, load valid_i=1, imm_i=0x1234, rdaddr_i=7 → next cycle valid_o=1, imm_o=0x1234, rdaddr_o=7.
- Load-use: EX holds a load (mem_o[0]=1, rtaddr_o=8); decode presents rsaddr_i=8 → hazard_o=1; next edge valid_o=0, ctrl=0, bubble_cnt_o=1; following edge loads the instruction with hazard_o=0.
- rt-only hazard: rtaddr_i=8 matches with uses_rt_i=0 → hazard_o=0; with uses_rt_i=1 → hazard_o=1. Repeat with rtaddr_o=0 → hazard_o=0.
- Stall: stall_i=1 for 3 cycles with changing inputs → all outputs and bubble_cnt_o unchanged; the first edge after release loads the current inputs.
- Flush versus hazard: flush_i=1 together with a matching load-use → hazard_o=0, a single bubble, counter +1; with stall_i also 1 → no change.
- Saturation: CNT_W=2, force 5 consecutive flushes → bubble_cnt_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid tracking, stall hold, flush/load-use bubbles and a saturating bubble counter
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int WB_W       = 2,
    parameter int MEM_W      = 3,
    parameter int EX_W       = 4,
    parameter int MEM_RD_BIT = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [MEM_W-1:0]  mem_i,
    input  logic [EX_W-1:0]   ex_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rsdata_i,
    input  logic [DATA_W-1:0] rtdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rsaddr_i,
    input  logic [REG_AW-1:0] rtaddr_i,
    input  logic [REG_AW-1:0] rdaddr_i,
    input  logic              uses_rt_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              valid_o,
    output logic [WB_W-1:0]   wb_o,
    output logic [MEM_W-1:0]  mem_o,
    output logic [EX_W-1:0]   ex_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rsdata_o,
    output logic [DATA_W-1:0] rtdata_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rsaddr_o,
    output logic [REG_AW-1:0] rtaddr_o,
    output logic [REG_AW-1:0] rdaddr_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    logic raw_hz;
    logic bubble;
    logic cnt_sat;

    // A load in EX whose destination feeds a source of the decode instruction; r0 never hazards
    assign raw_hz = valid_o & mem_o[MEM_RD_BIT] & (rtaddr_o != '0) & valid_i &
                    ((rsaddr_i == rtaddr_o) | (uses_rt_i & (rtaddr_i == rtaddr_o)));
    assign hazard_o = raw_hz & ~flush_i;
    assign bubble   = flush_i | hazard_o;
    assign cnt_sat  = &bubble_cnt_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            wb_o         <= '0;
            mem_o        <= '0;
            ex_o         <= '0;
            pc_o         <= '0;
            rsdata_o     <= '0;
            rtdata_o     <= '0;
            imm_o        <= '0;
            rsaddr_o     <= '0;
            rtaddr_o     <= '0;
            rdaddr_o     <= '0;
            bubble_cnt_o <= '0;
        end else if (!stall_i) begin
            if (bubble) begin
                // Data and address fields keep their old contents; only control is squashed
                valid_o      <= 1'b0;
                wb_o         <= '0;
                mem_o        <= '0;
                ex_o         <= '0;
                bubble_cnt_o <= cnt_sat ? bubble_cnt_o : bubble_cnt_o + CNT_W'(1);
            end else begin
                valid_o  <= valid_i;
                wb_o     <= valid_i ? wb_i : '0;
                mem_o    <= valid_i ? mem_i : '0;
                ex_o     <= valid_i ? ex_i : '0;
                pc_o     <= pc_i;
                rsdata_o <= rsdata_i;
                rtdata_o <= rtdata_i;
                imm_o    <= imm_i;
                rsaddr_o <= rsaddr_i;
                rtaddr_o <= rtaddr_i;
                rdaddr_o <= rdaddr_i;
            end
        end
    end
endmodule
